// File: rtl/isa_pkg.sv
// Shared ISA constants and types for the fetch path: instruction encodings,
// opcode field position, fetch FSM states and the default program start address.
package isa_pkg;

    localparam logic [15:0] NOP_WORD         = 16'hA800;
    localparam logic [2:0]  IMM_OP           = 3'b001;
    localparam int          OPC_HI           = 15;
    localparam int          OPC_LO           = 13;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd32;

    typedef enum logic [0:0] {
        FETCH     = 1'b0,
        FETCH_IMM = 1'b1
    } fetch_state_t;

    // True when the word is the first half of a two-word LDM instruction
    function automatic logic is_imm_op(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == IMM_OP;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its next-PC mux: redirect target, hold, or +1.
// The PC wraps silently from all-ones to zero.
module fetch_pc
    import isa_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc
);

    // Redirect beats hold; otherwise step to the next word every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_addr;
        end else if (!hold) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives imem_addr from the PC, pairs LDM with its
// trailing immediate word, and registers the IF/ID outputs. Supports stall
// (hold everything) and redirect (new PC, squash any partial LDM).
module fetch_stage
    import isa_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       if_id_instr,
    output logic [15:0]       if_id_imm,
    output logic              if_id_valid
);

    fetch_state_t state;
    logic [15:0]  hold_reg;
    logic [ADDR_W-1:0] pc;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk           (clk),
        .reset         (reset),
        .hold          (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .pc            (pc)
    );

    assign imem_addr = pc;

    // Fetch FSM: one-word instructions pass straight through; LDM parks its
    // opcode word in hold_reg and emits a bubble until the immediate arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            hold_reg    <= '0;
            if_id_instr <= NOP_WORD;
            if_id_imm   <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            state       <= FETCH;
            hold_reg    <= '0;
            if_id_instr <= NOP_WORD;
            if_id_imm   <= '0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            case (state)
                FETCH: begin
                    if (is_imm_op(imem_data)) begin
                        hold_reg    <= imem_data;
                        if_id_instr <= NOP_WORD;
                        if_id_imm   <= '0;
                        if_id_valid <= 1'b0;
                        state       <= FETCH_IMM;
                    end else begin
                        if_id_instr <= imem_data;
                        if_id_imm   <= '0;
                        if_id_valid <= 1'b1;
                    end
                end
                FETCH_IMM: begin
                    if_id_instr <= hold_reg;
                    if_id_imm   <= imem_data;
                    if_id_valid <= 1'b1;
                    state       <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset values, straight-line fetch, LDM
// pairing, stall inside an LDM, redirect overriding stall, and PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic        if_id_valid;

    logic        w_reset;
    logic [31:0] w_imem_addr;
    logic [15:0] w_imem_data;
    logic [15:0] w_if_id_instr;
    logic [15:0] w_if_id_imm;
    logic        w_if_id_valid;

    logic [15:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'd32)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_imm     (if_id_imm),
        .if_id_valid   (if_id_valid)
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk           (clk),
        .reset         (w_reset),
        .stall         (1'b0),
        .redirect      (1'b0),
        .redirect_addr (32'd0),
        .imem_addr     (w_imem_addr),
        .imem_data     (w_imem_data),
        .if_id_instr   (w_if_id_instr),
        .if_id_imm     (w_if_id_imm),
        .if_id_valid   (w_if_id_valid)
    );

    // Combinational instruction memory; addresses outside the table read NOP
    assign imem_data   = (imem_addr   < 32'd256) ? mem[imem_addr[7:0]]   : 16'hA800;
    assign w_imem_data = (w_imem_addr < 32'd256) ? mem[w_imem_addr[7:0]] : 16'hA800;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset_mid_cycle();
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA800;
        reset         = 1'b1;
        w_reset       = 1'b1;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'd0;

        // Reset state
        step_clock();
        check_output("rst_addr",  imem_addr,   32'd32);
        check_output("rst_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        check_output("rst_imm",   {16'd0, if_id_imm},   32'd0);
        check_output("rst_valid", {31'd0, if_id_valid}, 32'd0);

        // Straight-line one-word instructions
        mem[32] = 16'h6BE0;
        mem[33] = 16'hA800;
        release_reset();
        step_clock();
        check_output("sl1_instr", {16'd0, if_id_instr}, 32'h0000_6BE0);
        check_output("sl1_valid", {31'd0, if_id_valid}, 32'd1);
        check_output("sl1_addr",  imem_addr,   32'd33);
        step_clock();
        check_output("sl2_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        check_output("sl2_valid", {31'd0, if_id_valid}, 32'd1);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        pulse_reset_mid_cycle();
        check_output("arst_addr",  imem_addr,   32'd32);
        check_output("arst_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        check_output("arst_valid", {31'd0, if_id_valid}, 32'd0);

        // LDM pairing
        mem[32] = 16'h2800;
        mem[33] = 16'd15;
        release_reset();
        step_clock();
        check_output("ldm1_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        check_output("ldm1_valid", {31'd0, if_id_valid}, 32'd0);
        check_output("ldm1_addr",  imem_addr,   32'd33);
        step_clock();
        check_output("ldm2_instr", {16'd0, if_id_instr}, 32'h0000_2800);
        check_output("ldm2_imm",   {16'd0, if_id_imm},   32'd15);
        check_output("ldm2_valid", {31'd0, if_id_valid}, 32'd1);
        check_output("ldm2_addr",  imem_addr,   32'd34);

        // Stall while waiting for the LDM immediate
        pulse_reset_mid_cycle();
        mem[33] = 16'h0007;
        mem[34] = 16'h6BE0;
        release_reset();
        step_clock();
        check_output("stl0_addr", imem_addr, 32'd33);
        stall = 1'b1;
        step_clock();
        check_output("stl1_addr",  imem_addr,   32'd33);
        check_output("stl1_valid", {31'd0, if_id_valid}, 32'd0);
        check_output("stl1_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        step_clock();
        check_output("stl2_addr",  imem_addr,   32'd33);
        check_output("stl2_valid", {31'd0, if_id_valid}, 32'd0);
        stall = 1'b0;
        step_clock();
        check_output("stl3_instr", {16'd0, if_id_instr}, 32'h0000_2800);
        check_output("stl3_imm",   {16'd0, if_id_imm},   32'h0000_0007);
        check_output("stl3_valid", {31'd0, if_id_valid}, 32'd1);
        check_output("stl3_addr",  imem_addr,   32'd34);
        step_clock();
        check_output("stl4_instr", {16'd0, if_id_instr}, 32'h0000_6BE0);
        check_output("stl4_imm",   {16'd0, if_id_imm},   32'd0);
        check_output("stl4_addr",  imem_addr,   32'd35);

        // Redirect wins over stall and drops the partial LDM
        pulse_reset_mid_cycle();
        mem[100] = 16'h6123;
        release_reset();
        step_clock();
        check_output("rd0_addr", imem_addr, 32'd33);
        stall         = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'd100;
        step_clock();
        check_output("rd1_addr",  imem_addr,   32'd100);
        check_output("rd1_valid", {31'd0, if_id_valid}, 32'd0);
        check_output("rd1_instr", {16'd0, if_id_instr}, 32'h0000_A800);
        stall    = 1'b0;
        redirect = 1'b0;
        step_clock();
        check_output("rd2_instr", {16'd0, if_id_instr}, 32'h0000_6123);
        check_output("rd2_imm",   {16'd0, if_id_imm},   32'd0);
        check_output("rd2_valid", {31'd0, if_id_valid}, 32'd1);
        check_output("rd2_addr",  imem_addr,   32'd101);

        // PC wraps from all-ones to zero
        check_output("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFF);
        @(posedge clk);
        #1 w_reset = 1'b0;
        step_clock();
        check_output("wrap_addr",  w_imem_addr,   32'd0);
        check_output("wrap_instr", {16'd0, w_if_id_instr}, 32'h0000_A800);
        check_output("wrap_valid", {31'd0, w_if_id_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
